adc_dual_reader: RTL

Serial ADC front end that serves the control micro's conversion request and delivers the two 18-bit operands it consumes: the reference (`ref`) and the potentiometer/feedback (`pot`). On a rising edge of `ena_adc`, it runs one SPI-style frame on a dual-channel 12-bit ADC (two data lines, shared `cs_n`/`sclk`) and deshifts both channels in parallel. It then presents the results, held stable, together with a one-cycle `valid` strobe. It sits between the board ADC pins and the micro's REF/POT inputs.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_sclk_gen.sv | 62 ++++++
 rtl/adc_dual_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the dual-channel serial ADC reader: frame geometry,
// output width and the frame FSM state encoding.
package adc_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int LEAD_ZEROS  = 4;
    localparam int SAMPLE_BITS = FRAME_BITS - LEAD_ZEROS;
    localparam int DATA_W      = 18;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE,
        QUIET
    } adc_state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator for one ADC frame: sclk low half then high half per bit,
// a registered rise_tick in the first high cycle and a 4-bit bit counter.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    output logic       sclk,
    output logic       rise_tick,
    output logic       fall_tick,
    output logic [3:0] bit_cnt
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div_cnt;
    logic          half_end;
    logic          last_bit;

    assign half_end  = (div_cnt == CW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == 4'(FRAME_BITS - 1));
    // High in the last cycle of a high half: sclk drops (or the frame ends) at the next edge.
    assign fall_tick = run & sclk & half_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk      <= 1'b1;
            rise_tick <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end else if (start) begin
            sclk      <= 1'b0;
            rise_tick <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end else if (run) begin
            rise_tick <= 1'b0;
            if (half_end) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk      <= 1'b1;
                    rise_tick <= 1'b1;
                end else if (!last_bit) begin
                    sclk    <= 1'b0;
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else begin
            sclk      <= 1'b1;
            rise_tick <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end
    end

endmodule

// File: rtl/adc_dual_reader.sv
// Dual-channel 12-bit serial ADC front end delivering REF/POT operands with a valid strobe.
// Optional build macro ADC_SIGNED_EN selects offset-binary to two's complement output.
module adc_dual_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_adc,
    input  logic              sdata0,
    input  logic              sdata1,
    output logic              cs_n,
    output logic              sclk,
    output logic [DATA_W-1:0] ref_data,
    output logic [DATA_W-1:0] pot_data,
    output logic              valid,
    output logic              busy
);

    localparam int QW = $clog2(QUIET_CYC + 1);

    adc_state_t             state;
    logic                   ena_q;
    logic                   req;
    logic                   start;
    logic                   rise_tick;
    logic                   fall_tick;
    logic [3:0]             bit_cnt;
    logic                   frame_end;
    logic [QW-1:0]          quiet_cnt;
    logic [SAMPLE_BITS-1:0] sh0;
    logic [SAMPLE_BITS-1:0] sh1;

    function automatic logic [DATA_W-1:0] fmt_sample(input logic [SAMPLE_BITS-1:0] s);
`ifdef ADC_SIGNED_EN
        logic signed [SAMPLE_BITS-1:0] t;
        t = {~s[SAMPLE_BITS-1], s[SAMPLE_BITS-2:0]};  // s - 2048
        return {{(DATA_W - SAMPLE_BITS){t[SAMPLE_BITS-1]}}, t};
`else
        return {{(DATA_W - SAMPLE_BITS){1'b0}}, s};
`endif
    endfunction

    assign req       = ena_adc & ~ena_q;
    assign start     = req & (state == IDLE);
    assign frame_end = fall_tick & (bit_cnt == 4'(FRAME_BITS - 1));

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .run       (state == CONV),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .bit_cnt   (bit_cnt)
    );

    // Only the sample window is kept; the leading zero bits shift out the top.
    always_ff @(posedge clk) begin
        if (state == CONV && rise_tick) begin
            sh0 <= {sh0[SAMPLE_BITS-2:0], sdata0};
            sh1 <= {sh1[SAMPLE_BITS-2:0], sdata1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ena_q     <= 1'b0;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b0;
            ref_data  <= '0;
            pot_data  <= '0;
            quiet_cnt <= '0;
        end else begin
            ena_q <= ena_adc;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= CONV;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                CONV: begin
                    if (frame_end) begin
                        state    <= DONE;
                        cs_n     <= 1'b1;
                        valid    <= 1'b1;
                        ref_data <= fmt_sample(sh0);
                        pot_data <= fmt_sample(sh1);
                    end
                end
                DONE: begin
                    state     <= QUIET;
                    quiet_cnt <= '0;
                end
                QUIET: begin
                    if (quiet_cnt == QW'(QUIET_CYC - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
